neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_sequencer_if.sv | 78 +++++++
 rtl/neuron_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_neuron_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_sequencer_if.sv
// ---------------------------------------------------------------------------
// neuron_sequencer_if
//
// Purpose : Bundles the control-side handshake and the memory/datapath
//           address bus of the neuron layer sequencer into one interface.
//
// Signals :
//   start      - layer start request (controller -> sequencer)
//   hidden_in  - layer type sampled with an accepted start (1 = hidden)
//   stall      - freeze request from the memory side
//   val_addr   - value memory address (input index)
//   wgt_addr   - weight memory address (neuron*N_IN + input)
//   bias_addr  - bias memory address (neuron index)
//   dp_clr     - accumulator clear strobe
//   ld         - accumulator load enable
//   ready      - activation output valid strobe
//   hidden     - latched layer type for the datapath
//   res_we     - result write enable
//   res_addr   - result address (neuron index)
//   busy       - layer in progress
//   done       - one-cycle layer-complete pulse
//
// Modports:
//   master - the side that issues start/stall and consumes the addresses
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface neuron_sequencer_if #(
    parameter int AW = 8
);
    logic          start;
    logic          hidden_in;
    logic          stall;
    logic [AW-1:0] val_addr;
    logic [AW-1:0] wgt_addr;
    logic [AW-1:0] bias_addr;
    logic          dp_clr;
    logic          ld;
    logic          ready;
    logic          hidden;
    logic          res_we;
    logic [AW-1:0] res_addr;
    logic          busy;
    logic          done;

    modport master (
        output start,
        output hidden_in,
        output stall,
        input  val_addr,
        input  wgt_addr,
        input  bias_addr,
        input  dp_clr,
        input  ld,
        input  ready,
        input  hidden,
        input  res_we,
        input  res_addr,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  hidden_in,
        input  stall,
        output val_addr,
        output wgt_addr,
        output bias_addr,
        output dp_clr,
        output ld,
        output ready,
        output hidden,
        output res_we,
        output res_addr,
        output busy,
        output done
    );
endinterface

// File: rtl/neuron_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_sequencer
//
// Purpose : Control sequencer for one fully-connected neural network layer.
//           For every neuron it clears the accumulator (CLR), streams N_IN
//           value/weight address pairs into the MAC datapath (MAC), then
//           strobes the activation result into the result memory (ACT).
//           After the last neuron a one-cycle done pulse is issued (DONE).
//
// Parameters:
//   N_IN  - inputs per neuron (>= 1)
//   N_NEU - neurons per layer (>= 1)
//   AW    - address width, N_IN*N_NEU <= 2**AW
//
// Ports   :
//   clk   - single clock, rising edge
//   rst   - synchronous, active-high reset
//   bus   - neuron_sequencer_if slave modport (start/stall in,
//           addresses and strobes out)
//
// Timing  : start accepted at edge k -> done high in cycle k+1+N_NEU*(N_IN+2)
//           when no stall occurs; every stalled CLR/MAC/ACT cycle adds one.
// ---------------------------------------------------------------------------
module neuron_sequencer #(
    parameter int N_IN  = 8,
    parameter int N_NEU = 4,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    neuron_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_MAC  = 3'd2,
        S_ACT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [AW-1:0] IN_LAST  = AW'(N_IN - 1);
    localparam logic [AW-1:0] NEU_LAST = AW'(N_NEU - 1);
    // Only added when another neuron follows, so it never overflows for
    // legal parameter sets even when N_IN == 2**AW (then N_NEU == 1).
    localparam logic [AW-1:0] IN_STEP  = AW'(N_IN);

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic [AW-1:0] in_cnt_q,   in_cnt_d;
    logic [AW-1:0] neu_cnt_q,  neu_cnt_d;
    // Running neu_cnt*N_IN, kept as a register so the weight address is a
    // single adder instead of a multiplier.
    logic [AW-1:0] wgt_base_q, wgt_base_d;
    logic          hidden_q,   hidden_d;

    // -----------------------------------------------------------------------
    // Decoded outputs
    // -----------------------------------------------------------------------
    logic [AW-1:0] val_addr;
    logic [AW-1:0] wgt_addr;
    logic [AW-1:0] res_addr;
    logic          dp_clr;
    logic          ld;
    logic          ready;
    logic          res_we;
    logic          busy;
    logic          done;
    logic          run;

    // A stall freezes CLR/MAC/ACT; IDLE and DONE ignore it.
    assign run = ~bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_cnt_q   <= '0;
            neu_cnt_q  <= '0;
            wgt_base_q <= '0;
            hidden_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            neu_cnt_q  <= neu_cnt_d;
            wgt_base_q <= wgt_base_d;
            hidden_q   <= hidden_d;
        end
    end

    always_comb begin
        // hold everything unless a state advances
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        neu_cnt_d  = neu_cnt_q;
        wgt_base_d = wgt_base_q;
        hidden_d   = hidden_q;

        val_addr   = '0;
        wgt_addr   = '0;
        res_addr   = '0;
        dp_clr     = 1'b0;
        ld         = 1'b0;
        ready      = 1'b0;
        res_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    hidden_d   = bus.hidden_in;
                    in_cnt_d   = '0;
                    neu_cnt_d  = '0;
                    wgt_base_d = '0;
                    state_d    = S_CLR;
                end
            end

            S_CLR: begin
                busy = 1'b1;
                if (run) begin
                    dp_clr  = 1'b1;
                    state_d = S_MAC;
                end
            end

            S_MAC: begin
                busy     = 1'b1;
                // addresses stay valid while stalled so memory can retry
                val_addr = in_cnt_q;
                wgt_addr = wgt_base_q + in_cnt_q;
                if (run) begin
                    ld = 1'b1;
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        state_d  = S_ACT;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end

            S_ACT: begin
                busy     = 1'b1;
                res_addr = neu_cnt_q;
                if (run) begin
                    ready  = 1'b1;
                    res_we = 1'b1;
                    if (neu_cnt_q == NEU_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        neu_cnt_d  = neu_cnt_q + 1'b1;
                        wgt_base_d = wgt_base_q + IN_STEP;
                        state_d    = S_CLR;
                    end
                end
            end

            S_DONE: begin
                // start in this cycle is deliberately not looked at
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Interface drive
    // -----------------------------------------------------------------------
    assign bus.val_addr  = val_addr;
    assign bus.wgt_addr  = wgt_addr;
    assign bus.bias_addr = neu_cnt_q;
    assign bus.dp_clr    = dp_clr;
    assign bus.ld        = ld;
    assign bus.ready     = ready;
    assign bus.hidden    = hidden_q;
    assign bus.res_we    = res_we;
    assign bus.res_addr  = res_addr;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_neuron_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_sequencer
//
// Drives two sequencer instances (8x4 and 1x1) with randomized start,
// hidden_in and stall patterns. The reference is a per-layer work list:
// accepting start fills a queue with CLR / MAC(i) / ACT per neuron and a
// final DONE; each unstalled cycle retires one entry. Expected outputs of
// a cycle follow from the head entry and the current stall input.
// ---------------------------------------------------------------------------
module tb_neuron_sequencer;

    localparam int AW = 8;

    localparam int K_CLR  = 0;
    localparam int K_MAC  = 1;
    localparam int K_ACT  = 2;
    localparam int K_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_sequencer_if #(.AW(AW)) ifa ();
    neuron_sequencer_if #(.AW(AW)) ifb ();

    neuron_sequencer #(.N_IN(8), .N_NEU(4), .AW(AW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    neuron_sequencer #(.N_IN(1), .N_NEU(1), .AW(AW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        int kind;
        int n;
        int i;
    } item_t;

    item_t q[$];
    int    nin  [2] = '{8, 1};
    int    nneu [2] = '{4, 1};
    bit    hid_m  [2];
    int    bias_m [2];

    int total = 0;
    int bad   = 0;
    int edge_cnt  = 0;
    int acc_edge  = 0;
    int stall_cnt = 0;
    int done_lat  = 0;
    bit done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_layer(input int d);
        item_t it;
        for (int n = 0; n < nneu[d]; n++) begin
            it.kind = K_CLR; it.n = n; it.i = 0; q.push_back(it);
            for (int i = 0; i < nin[d]; i++) begin
                it.kind = K_MAC; it.n = n; it.i = i; q.push_back(it);
            end
            it.kind = K_ACT; it.n = n; it.i = 0; q.push_back(it);
        end
        it.kind = K_DONE; it.n = nneu[d] - 1; it.i = 0; q.push_back(it);
    endtask

    // One clock cycle: entered #1 after a rising edge, leaves #1 after the next.
    task automatic step(input int d, input bit st, input bit hin, input bit stl, input bit rs);
        logic [6:0]    exp_ctl, got_ctl;
        int            ev, ew, eb, er;
        logic [AW-1:0] gv, gw, gb, gr;
        item_t         it;

        rst           = rs;
        ifa.start     = (d == 0) ? st  : 1'b0;
        ifa.hidden_in = (d == 0) ? hin : 1'b0;
        ifa.stall     = (d == 0) ? stl : 1'b0;
        ifb.start     = (d == 1) ? st  : 1'b0;
        ifb.hidden_in = (d == 1) ? hin : 1'b0;
        ifb.stall     = (d == 1) ? stl : 1'b0;

        @(negedge clk);
        // expected {dp_clr, ld, ready, res_we, busy, done, hidden}
        ev = 0; ew = 0; er = 0; eb = bias_m[d];
        exp_ctl = {6'b0, hid_m[d]};
        if (q.size() != 0) begin
            it = q[0];
            eb = it.n;
            exp_ctl[2] = 1'b1;
            case (it.kind)
                K_CLR:  exp_ctl[6] = !stl;
                K_MAC: begin
                    exp_ctl[5] = !stl;
                    ev = it.i;
                    ew = it.n * nin[d] + it.i;
                end
                K_ACT: begin
                    exp_ctl[4] = !stl;
                    exp_ctl[3] = !stl;
                    er = it.n;
                end
                default: exp_ctl[1] = 1'b1;
            endcase
        end

        if (d == 0) begin
            got_ctl = {ifa.dp_clr, ifa.ld, ifa.ready, ifa.res_we, ifa.busy, ifa.done, ifa.hidden};
            gv = ifa.val_addr; gw = ifa.wgt_addr; gb = ifa.bias_addr; gr = ifa.res_addr;
        end else begin
            got_ctl = {ifb.dp_clr, ifb.ld, ifb.ready, ifb.res_we, ifb.busy, ifb.done, ifb.hidden};
            gv = ifb.val_addr; gw = ifb.wgt_addr; gb = ifb.bias_addr; gr = ifb.res_addr;
        end

        chk("ctl", 32'(got_ctl), 32'(exp_ctl));
        chk("val_addr", 32'(gv), 32'(ev));
        chk("wgt_addr", 32'(gw), 32'(ew));
        chk("bias_addr", 32'(gb), 32'(eb));
        chk("res_addr", 32'(gr), 32'(er));
        if (d == 0 && q.size() != 0 && q[0].kind == K_MAC && q[0].n == 2 && q[0].i == 5) begin
            chk("wgt_n2_i5", 32'(gw), 32'd21);
            chk("val_n2_i5", 32'(gv), 32'd5);
            chk("bias_n2_i5", 32'(gb), 32'd2);
        end
        if (got_ctl[1] && !rs) begin
            done_seen = 1'b1;
            done_lat  = edge_cnt + 1 - acc_edge;
        end

        @(posedge clk);
        edge_cnt++;
        if (rs) begin
            q.delete();
            hid_m  = '{1'b0, 1'b0};
            bias_m = '{0, 0};
        end else if (q.size() == 0) begin
            if (st) begin
                hid_m[d]  = hin;
                bias_m[d] = 0;
                acc_edge  = edge_cnt;
                stall_cnt = 0;
                done_seen = 1'b0;
                fill_layer(d);
            end
        end else begin
            it = q[0];
            if (stl && it.kind != K_DONE) begin
                stall_cnt++;
            end else begin
                if (it.kind == K_DONE) bias_m[d] = it.n;
                void'(q.pop_front());
            end
        end
        #1;
    endtask

    // Start a layer and run it to completion. fix3 forces a 3-cycle stall
    // at neuron 1, input 3; repulse_pct re-asserts start with the opposite
    // hidden_in while the layer is running.
    task automatic run_layer(input int d, input bit hin, input int stall_pct,
                             input int repulse_pct, input bit fix3);
        int fix_left;
        int guard;
        bit stl, st;
        fix_left = fix3 ? 3 : 0;
        guard    = 0;
        step(d, 1'b1, hin, 1'($urandom_range(0, 1)), 1'b0);
        while (q.size() != 0 && guard < 500) begin
            stl = ($urandom_range(0, 99) < stall_pct);
            if (fix_left > 0 && q[0].kind == K_MAC && q[0].n == 1 && q[0].i == 3) begin
                stl = 1'b1;
                fix_left--;
            end
            st = ($urandom_range(0, 99) < repulse_pct);
            step(d, st, !hin, stl, 1'b0);
            guard++;
        end
        chk("done_seen", 32'(done_seen), 32'd1);
    endtask

    task automatic idle_gap(input int d, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step(d, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        ifa.start = 0; ifa.hidden_in = 0; ifa.stall = 0;
        ifb.start = 0; ifb.hidden_in = 0; ifb.stall = 0;
        hid_m  = '{1'b0, 1'b0};
        bias_m = '{0, 0};
        @(posedge clk);
        #1;

        // reset, with reset winning over start and stall
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_gap(0, 2);

        // plain hidden layer
        run_layer(0, 1'b1, 0, 0, 1'b0);
        chk("lat_plain", 32'(done_lat), 32'd41);
        $display("layer dut=a hidden=1 stalls=%0d latency=%0d", stall_cnt, done_lat);
        idle_gap(0, 2);

        // 3-cycle stall mid-MAC plus start re-pulses with hidden_in=0
        run_layer(0, 1'b1, 0, 30, 1'b1);
        chk("stall_cnt_fix", 32'(stall_cnt), 32'd3);
        chk("lat_stall3", 32'(done_lat), 32'd44);
        $display("layer dut=a hidden=1 stalls=%0d latency=%0d", stall_cnt, done_lat);
        idle_gap(0, 1);

        // random layers
        for (int r = 0; r < 6; r++) begin
            bit h;
            h = 1'($urandom_range(0, 1));
            run_layer(0, h, 20, 20, 1'b0);
            chk("lat_rand", 32'(done_lat), 32'(41 + stall_cnt));
            $display("layer dut=a hidden=%0d stalls=%0d latency=%0d", h, stall_cnt, done_lat);
            idle_gap(0, $urandom_range(0, 2));
        end

        // reset during ACT of neuron 1, then a full layer
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 100; g++) begin
            if (q.size() != 0 && q[0].kind == K_ACT && q[0].n == 1) break;
            step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("reached_act1", 32'(q.size() != 0 && q[0].kind == K_ACT && q[0].n == 1), 32'd1);
        step(0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_gap(0, 1);
        run_layer(0, 1'b0, 0, 0, 1'b0);
        chk("lat_after_rst", 32'(done_lat), 32'd41);
        $display("layer dut=a after reset stalls=%0d latency=%0d", stall_cnt, done_lat);
        idle_gap(0, 2);

        // minimal 1x1 layer
        run_layer(1, 1'b1, 0, 0, 1'b0);
        chk("lat_1x1", 32'(done_lat), 32'd4);
        $display("layer dut=b hidden=1 stalls=%0d latency=%0d", stall_cnt, done_lat);
        for (int r = 0; r < 4; r++) begin
            run_layer(1, 1'($urandom_range(0, 1)), 30, 30, 1'b0);
            chk("lat_1x1_rand", 32'(done_lat), 32'(4 + stall_cnt));
            $display("layer dut=b stalls=%0d latency=%0d", stall_cnt, done_lat);
            idle_gap(1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // absolute time bound in case anything above fails to advance
    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "simulation time bound expired");
    end

endmodule
